// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports:
//   clk    system clock; all state changes on the rising edge
//   reset  asynchronous active-low reset
//   Addr   bridge word address; Addr[3:2] selects CTRL/DIV/TXDAT/STAT
//   WE     single-cycle write strobe
//   Din    write data
//   Dout   combinational read data for the register selected by Addr[3:2]
//   IRQ    registered level interrupt: IE & FIFO empty & transmitter idle
//   tx     serial output, idle high, LSB first
module uart_tx_dev #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd5208
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        tx
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [1:0]      ctrl_q, ctrl_d;    // [0] TE, [1] IE
   logic [15:0]     div_q, div_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   state_e          state_q, state_d;
   logic [15:0]     bcnt_q, bcnt_d;
   logic [2:0]      bidx_q, bidx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            irq_q, irq_d;

   logic [1:0]  sel;
   logic        wr_ctrl, wr_div, wr_txdat, wr_stat;
   logic        empty, full, push, pop, bit_end;
   logic [15:0] div_eff;
   logic        unused_bits;

   // Only Addr[3:2] is decoded; upper data bits are ignored on writes.
   assign unused_bits = ^{Addr[29:4], Addr[1:0], Din[31:16]};

   always_comb begin
      sel      = Addr[3:2];
      wr_ctrl  = WE && (sel == 2'd0);
      wr_div   = WE && (sel == 2'd1);
      wr_txdat = WE && (sel == 2'd2);
      wr_stat  = WE && (sel == 2'd3);

      empty   = (cnt_q == '0);
      full    = (cnt_q == CntFull);
      div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
      // >= rather than == so a DIV shrunk mid-bit ends the bit on the next cycle
      bit_end = (bcnt_q >= (div_eff - 16'd1));

      pop  = (state_q == StIdle) && ctrl_q[0] && !empty;
      // Fullness is judged before this edge, so a same-edge pop cannot rescue the byte
      push = wr_txdat && !full;
   end

   // Register file and FIFO next state
   always_comb begin
      ctrl_d = ctrl_q;
      div_d  = div_q;
      ovf_d  = ovf_q;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;

      if (wr_ctrl) ctrl_d = Din[1:0];
      if (wr_div)  div_d  = Din[15:0];
      if (wr_stat) ovf_d  = 1'b0;
      if (wr_txdat && full) ovf_d = 1'b1;

      if (push) begin
         mem_d[wptr_q] = Din[7:0];
         wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end

      if (push && !pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Transmit FSM next state; tx is registered, so it changes on the transition edge
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      tx_d    = tx_q;

      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (pop) begin
               shift_d = mem_q[rptr_q];
               state_d = StStart;
               bcnt_d  = 16'd0;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bcnt_d  = 16'd0;
               bidx_d  = 3'd0;
               tx_d    = shift_q[0];
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               bcnt_d = 16'd0;
               if (bidx_q == 3'd7) begin
                  state_d = StStop;
                  tx_d    = 1'b1;
               end else begin
                  bidx_d = bidx_q + 3'd1;
                  tx_d   = shift_q[bidx_q + 3'd1];
               end
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               bcnt_d  = 16'd0;
               tx_d    = 1'b1;
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase

      irq_d = ctrl_q[1] && empty && (state_q == StIdle);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= 2'b00;
         div_q   <= DIV_RESET;
         mem_q   <= '{default: 8'h00};
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         state_q <= StIdle;
         bcnt_q  <= 16'd0;
         bidx_q  <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         div_q   <= div_d;
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      case (sel)
         2'd0:    Dout = {30'd0, ctrl_q};
         2'd1:    Dout = {16'd0, div_q};
         2'd2:    Dout = 32'd0;
         default: Dout = {24'd0, 4'(cnt_q), ovf_q, empty, full, (state_q != StIdle)};
      endcase
   end

   assign IRQ = irq_q;
   assign tx  = tx_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: self-checking bench for uart_tx_dev. A byte queue models the FIFO
// contents; each transmitted frame is captured off tx and compared with the 8N1 frame
// expected for the byte at the head of the queue.
module tb_uart_tx_dev;

   localparam int unsigned Depth  = 4;
   localparam logic [15:0] DivRst = 16'd5208;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        tx;

   always #5 clk = ~clk;

   uart_tx_dev #(
      .FIFO_DEPTH (Depth),
      .DIV_RESET  (DivRst)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ),
      .tx    (tx)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic       m_ovf;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] stat_exp(input int cnt, input logic ovf, input logic busy);
      logic [3:0] c;
      logic       e;
      logic       f;
      c = 4'(cnt);
      e = (cnt == 0);
      f = (cnt == int'(Depth));
      return {24'd0, c, ovf, e, f, busy};
   endfunction

   // Undecoded address bits are randomised to show they are ignored.
   task automatic set_addr(input logic [1:0] idx);
      Addr = {26'($urandom), idx, 2'($urandom)};
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
      set_addr(idx);
      WE  = 1'b1;
      Din = data;
      @(negedge clk);
      WE  = 1'b0;
      Din = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
      set_addr(idx);
      #1;
      data = Dout;
   endtask

   task automatic push_byte(input logic [7:0] b);
      if (exp_q.size() == int'(Depth)) m_ovf = 1'b1;
      else exp_q.push_back(b);
      bus_write(2'd2, {24'($urandom), b});
   endtask

   // Checks n back-to-back frames of d cycles per bit, each followed by one idle cycle.
   // pre: the first frame cycle is already on tx at the current time.
   task automatic run_frames(input int d, input int n, input bit pre, input logic irq_end);
      logic [31:0] st;
      for (int k = 0; k < n; k++) begin
         logic [9:0] got;
         int         glitch;
         logic [7:0] b;
         got    = '0;
         glitch = 0;
         b      = exp_q.pop_front();
         for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < d; c++) begin
               if (!(pre && k == 0 && s == 0 && c == 0)) @(negedge clk);
               if (c == 0) got[s] = tx;
               else if (tx !== got[s]) glitch++;
            end
         end
         check("frame", {22'd0, got}, {22'd0, 1'b1, b, 1'b0});
         check("frame_glitch", glitch, 0);
         @(negedge clk);
         check("gap_tx", {31'd0, tx}, 32'd1);
         check("gap_irq", {31'd0, IRQ}, 32'd0);
         bus_read(2'd3, st);
         check("gap_stat", st, stat_exp(exp_q.size(), m_ovf, 1'b0));
      end
      @(negedge clk);
      check("irq_end", {31'd0, IRQ}, {31'd0, irq_end});
   endtask

   initial begin
      logic [31:0] rd;
      logic [11:0] got12;
      logic [7:0]  b;
      int          bad;

      reset = 1'b1;
      WE    = 1'b0;
      Din   = 32'd0;
      Addr  = 30'd0;
      m_ovf = 1'b0;
      #2 reset = 1'b0;
      #10;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      bus_read(2'd3, rd); check("rst_stat", rd, 32'h4);
      bus_read(2'd1, rd); check("rst_div", rd, {16'd0, DivRst});
      bus_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single frame 0xA5 at DIV=4
      bus_write(2'd1, 32'hFFFF_0004);
      bus_read(2'd1, rd); check("div_rb", rd, 32'd4);
      bus_write(2'd0, 32'hFFFF_FFFD);
      bus_read(2'd0, rd); check("ctrl_rb", rd, 32'd1);
      bus_read(2'd2, rd); check("txdat_rd0", rd, 32'd0);
      push_byte(8'hA5);
      run_frames(4, 1, 1'b0, 1'b0);

      // Overflow with TE=0, then sticky clear
      bus_write(2'd0, 32'd0);
      push_byte(8'h3C); push_byte(8'hC3); push_byte(8'h00); push_byte(8'hFF); push_byte(8'h5A);
      bus_read(2'd3, rd); check("ovf_stat", rd, stat_exp(exp_q.size(), m_ovf, 1'b0));
      bus_write(2'd3, $urandom);
      m_ovf = 1'b0;
      bus_read(2'd3, rd); check("ovf_clr", rd, stat_exp(exp_q.size(), m_ovf, 1'b0));

      // Full FIFO: a push on the pop edge is dropped
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'd1);
      bus_write(2'd2, 32'hEE);
      m_ovf = 1'b1;
      bus_read(2'd3, rd); check("push_on_pop", rd, stat_exp(3, 1'b1, 1'b1));
      run_frames(3, 4, 1'b1, 1'b0);
      bus_write(2'd3, 32'd0);
      m_ovf = 1'b0;

      // IRQ around back-to-back frames at DIV=2
      bus_write(2'd1, 32'd2);
      bus_write(2'd0, 32'd3);
      @(negedge clk);
      check("irq_idle_empty", {31'd0, IRQ}, 32'd1);
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      check("irq_pending", {31'd0, IRQ}, 32'd0);
      run_frames(2, 2, 1'b1, 1'b1);

      // DIV shrunk to 1 during the start bit: start bit ends on the next cycle
      bus_write(2'd1, 32'd4);
      b = 8'($urandom);
      bus_write(2'd2, {24'd0, b});
      got12 = '0;
      @(negedge clk); got12[0] = tx;
      @(negedge clk); got12[1] = tx;
      bus_write(2'd1, 32'd1);
      got12[2] = tx;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         got12[3+i] = tx;
      end
      check("div_mid_bit", {20'd0, got12}, {20'd0, 1'b1, b, 3'b000});
      bus_read(2'd3, rd); check("stop_busy", {31'd0, rd[0]}, 32'd1);
      @(negedge clk);
      bus_read(2'd3, rd); check("div_mid_idle", rd, stat_exp(0, 1'b0, 1'b0));

      // DIV=0 acts as 1; TE cleared on the pop edge still finishes that frame only
      bus_write(2'd0, 32'd0);
      bus_write(2'd1, 32'd0);
      bus_read(2'd1, rd); check("div0_rb", rd, 32'd0);
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      bus_write(2'd0, 32'd1);
      bus_write(2'd0, 32'd0);
      run_frames(1, 1, 1'b1, 1'b0);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      check("te_off_idle_tx", bad, 0);
      bus_read(2'd3, rd); check("te_off_kept", rd, stat_exp(exp_q.size(), 1'b0, 1'b0));

      // Randomised bursts
      for (int it = 0; it < 8; it++) begin
         logic ie;
         int   dv;
         int   n;
         ie = 1'($urandom_range(0, 1));
         dv = $urandom_range(0, 4);
         n  = $urandom_range(1, Depth + 2);
         bus_write(2'd0, {30'($urandom), ie, 1'b0});
         bus_write(2'd1, {16'($urandom), 16'(dv)});
         bus_read(2'd1, rd); check("rnd_div_rb", rd, 32'(dv));
         for (int j = 0; j < n; j++) push_byte(8'($urandom));
         @(negedge clk);
         check("rnd_irq_pend", {31'd0, IRQ}, 32'd0);
         bus_read(2'd3, rd); check("rnd_stat", rd, stat_exp(exp_q.size(), m_ovf, 1'b0));
         if (m_ovf) begin
            bus_write(2'd3, $urandom);
            m_ovf = 1'b0;
         end
         bus_write(2'd0, {30'($urandom), ie, 1'b1});
         run_frames((dv == 0) ? 1 : dv, exp_q.size(), 1'b0, ie);
      end

      // Asynchronous reset in the middle of a frame of zeros
      bus_write(2'd1, 32'd4);
      bus_write(2'd0, 32'd3);
      bus_write(2'd2, 32'h00);
      repeat (7) @(negedge clk);
      check("pre_rst_tx_low", {31'd0, tx}, 32'd0);
      #2 reset = 1'b0;
      #1;
      check("midrst_tx", {31'd0, tx}, 32'd1);
      check("midrst_irq", {31'd0, IRQ}, 32'd0);
      bus_read(2'd3, rd); check("midrst_stat", rd, 32'h4);
      bus_read(2'd1, rd); check("midrst_div", rd, {16'd0, DivRst});
      bus_read(2'd0, rd); check("midrst_ctrl", rd, 32'd0);
      exp_q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("postrst_tx", {31'd0, tx}, 32'd1);
      bus_read(2'd3, rd); check("postrst_stat", rd, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
